// File: rtl/punc_mem_arbiter.sv
// Purpose : shares one single-port PUnC memory between the core port (0) and the
//           debug/loader port (1). Each transaction runs IDLE->ISSUE->WAIT->ACK.
// Latency : req first seen in IDLE cycle T -> mem_en at T+1 -> ack at T+2+MEM_LAT.
// Backpressure: requesters hold req until their one-cycle ack. Req is only sampled in IDLE.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-low reset
//   core_req/we/addr/wdata        core request, held stable until core_ack
//   core_ack, core_rdata          one-cycle completion pulse; read data (0 outside ack)
//   dbg_req/we/addr/wdata         debug/loader request, held stable until dbg_ack
//   dbg_ack, dbg_rdata            one-cycle completion pulse; read data (0 outside ack)
//   mem_en/we/addr/wdata          memory strobe (one cycle per transaction) and command
//   mem_rdata                     memory read data, valid MEM_LAT cycles after mem_en
//   busy, owner                   not-IDLE flag; port of the in-flight transaction
module punc_mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_LAT   = 1,   // 1..15
  parameter int FIXED_PRI = 0    // 1: dbg always wins a conflict
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  // WAIT runs MEM_LAT cycles: the counter is loaded with MEM_LAT-1 and the
  // cycle in which it reads zero is the last one.
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                owner_q, owner_d;
  logic                rr_last_q, rr_last_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  // Registered outputs
  logic                mem_en_q, mem_en_d;
  logic                busy_q, busy_d;
  logic                core_ack_q, core_ack_d;
  logic                dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;

  logic                pick_dbg;

  // dbg wins if it is the only requester, if fixed priority is on, or if
  // core was the last port served (round-robin).
  assign pick_dbg = dbg_req & (~core_req | (FIXED_PRI != 0) | ~rr_last_q);

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      owner_q      <= 1'b0;
      rr_last_q    <= 1'b1;   // core wins the first tie
      rdata_q      <= '0;
      mem_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      core_ack_q   <= 1'b0;
      dbg_ack_q    <= 1'b0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      owner_q      <= owner_d;
      rr_last_q    <= rr_last_d;
      rdata_q      <= rdata_d;
      mem_en_q     <= mem_en_d;
      busy_q       <= busy_d;
      core_ack_q   <= core_ack_d;
      dbg_ack_q    <= dbg_ack_d;
      core_rdata_q <= core_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // Next-state and datapath latch logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (core_req || dbg_req) begin
          owner_d = pick_dbg;
          we_d    = pick_dbg ? dbg_we    : core_we;
          addr_d  = pick_dbg ? dbg_addr  : core_addr;
          wdata_d = pick_dbg ? dbg_wdata : core_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT_M1;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          // Writes keep the previous read value in rdata_q.
          if (!we_q) rdata_d = mem_rdata;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        rr_last_d = owner_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode, computed from next state so the outputs can be registered
  always_comb begin
    mem_en_d     = (state_d == ISSUE);
    busy_d       = (state_d != IDLE);
    core_ack_d   = (state_d == ACK) && !owner_d;
    dbg_ack_d    = (state_d == ACK) &&  owner_d;
    core_rdata_d = core_ack_d ? rdata_d : '0;
    dbg_rdata_d  = dbg_ack_d  ? rdata_d : '0;
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = busy_q;
  assign owner      = owner_q;
  assign core_ack   = core_ack_q;
  assign dbg_ack    = dbg_ack_q;
  assign core_rdata = core_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule
